// File: rtl/gcd_pkg.sv
// gcd_pkg: shared encodings for the multimode GCD unit.
//   state_t  : controller states (IDLE -> CALC -> DONE -> IDLE)
//   MODE_SUB : subtractive Euclid step selection
//   MODE_BIN : binary (Stein) step selection
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step_datapath.sv
// gcd_step_datapath: one combinational GCD iteration.
//   i_a, i_b   current operands
//   i_k        common power-of-two count (binary mode only)
//   i_mode     MODE_SUB or MODE_BIN
//   o_a, o_b   operands after this step
//   o_k        power-of-two count after this step
//   o_finish   termination reached (an operand is 0 or both are equal)
//   o_result   (A|B)<<k, meaningful when o_finish is set
module gcd_step_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [KW-1:0]    o_k,
    output logic             o_finish,
    output logic [WIDTH-1:0] o_result
);

    logic             w_a_gt_b;
    logic [WIDTH-1:0] w_a_minus_b;
    logic [WIDTH-1:0] w_b_minus_a;

    assign w_a_gt_b    = (i_a > i_b);
    // Only the difference with the larger operand as minuend is ever selected.
    assign w_a_minus_b = i_a - i_b;
    assign w_b_minus_a = i_b - i_a;

    // When one operand is 0 the OR is the other one; when equal it is either.
    assign o_finish = (i_a == '0) || (i_b == '0) || (i_a == i_b);
    assign o_result = (i_a | i_b) << i_k;

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        o_k = i_k;
        if (i_mode == MODE_SUB) begin
            if (w_a_gt_b) o_a = w_a_minus_b;
            else          o_b = w_b_minus_a;
        end else begin
            unique case ({i_a[0], i_b[0]})
                2'b00: begin
                    o_a = i_a >> 1;
                    o_b = i_b >> 1;
                    o_k = i_k + 1'b1;
                end
                2'b01: o_a = i_a >> 1;
                2'b10: o_b = i_b >> 1;
                default: begin
                    // Difference of two odd numbers is even, so halve it in the same step.
                    if (w_a_gt_b) o_a = w_a_minus_b >> 1;
                    else          o_b = w_b_minus_a >> 1;
                end
            endcase
        end
    end

endmodule

// File: rtl/gcd_multimode_unit.sv
// gcd_multimode_unit: GCD engine with per-operation choice of subtractive
// Euclid (mode 0) or binary Stein (mode 1).
//   clk, rst              clock, async active-low reset
//   start/in_ready        command handshake, a_in/b_in/mode sampled on accept
//   abort                 cancel the current operation (CALC or DONE)
//   busy                  high while iterating
//   gcd_out/zero_err/cycles result fields, valid with out_valid
//   out_valid/out_ready   result handshake
module gcd_multimode_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err,
    output logic [CNT_W-1:0] cycles,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_mode;
    logic [WIDTH-1:0] r_gcd;
    logic             r_zero_err;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_finish;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_step;

    gcd_step_datapath #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .i_mode   (r_mode),
        .o_a      (w_a_nxt),
        .o_b      (w_b_nxt),
        .o_k      (w_k_nxt),
        .o_finish (w_finish),
        .o_result (w_result)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CALC);
    assign out_valid = (r_state == ST_DONE);
    assign gcd_out   = r_gcd;
    assign zero_err  = r_zero_err;
    assign cycles    = r_cnt;

    assign w_accept = in_ready && start;
    // An aborted CALC cycle leaves the datapath untouched; it is restarted on next accept.
    assign w_step   = busy && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (abort)         w_state_nxt = ST_IDLE;
                else if (w_finish) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // abort wins over a simultaneous result handshake
                if (abort || out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_mode     <= MODE_SUB;
            r_gcd      <= '0;
            r_zero_err <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_k        <= '0;
            r_mode     <= mode;
            r_zero_err <= (a_in == '0) && (b_in == '0);
            r_cnt      <= '0;
        end else if (w_step) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
                r_gcd <= w_result;
            end else begin
                r_a <= w_a_nxt;
                r_b <= w_b_nxt;
                r_k <= w_k_nxt;
            end
        end
    end

endmodule
